// File: rtl/arb_nm1s.sv
// N-master / 1-slave round-robin arbiter for the split-transaction memory bus.
// Grants are locked until the slave acknowledges; read IDs are queued so in-order responses route back.
module arb_nm1s #(
  parameter  int NUM_M     = 4,
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 32,
  parameter  int MAX_OUTST = 4,
  localparam int BE_W      = DATA_W / 8,
  localparam int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_M-1:0]         m_req_i,
  input  logic [NUM_M-1:0]         m_we_i,
  input  logic [NUM_M*ADDR_W-1:0]  m_addr_i,
  input  logic [NUM_M*BE_W-1:0]    m_be_i,
  input  logic [NUM_M*DATA_W-1:0]  m_wdata_i,
  output logic [NUM_M-1:0]         m_ack_o,
  output logic [NUM_M-1:0]         m_resp_o,
  output logic [NUM_M*DATA_W-1:0]  m_rdata_o,
  output logic                     s_req_o,
  output logic                     s_we_o,
  output logic [ADDR_W-1:0]        s_addr_o,
  output logic [BE_W-1:0]          s_be_o,
  output logic [DATA_W-1:0]        s_wdata_o,
  input  logic                     s_ack_i,
  input  logic                     s_resp_i,
  input  logic [DATA_W-1:0]        s_rdata_i,
  output logic [CNT_W-1:0]         outst_cnt_o,
  output logic                     err_o
);

  localparam int ID_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  function automatic logic [ID_W-1:0] f_id_inc(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_M - 1)) ? '0 : id + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [ID_W-1:0]  r_rr_ptr;
  logic             r_lock;
  logic [ID_W-1:0]  r_lock_id;
  logic [ID_W-1:0]  r_fifo [MAX_OUTST];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic [NUM_M-1:0] w_elig;
  logic [ID_W-1:0]  w_scan_win;
  logic             w_scan_vld;
  logic [ID_W-1:0]  w_win;
  logic             w_vld;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic [ID_W-1:0]  w_head;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CNT_W'(MAX_OUTST));
  assign w_head  = r_fifo[r_rptr];

  // Reads are masked while the ID FIFO is full; writes never need a slot.
  assign w_elig = m_req_i & (m_we_i | {NUM_M{~w_full}});

  always_comb begin
    logic [ID_W:0] v_sum;
    logic [ID_W-1:0] v_idx;
    w_scan_win = '0;
    w_scan_vld = 1'b0;
    v_sum      = '0;
    v_idx      = '0;
    for (int k = 0; k < NUM_M; k++) begin
      v_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (v_sum >= (ID_W+1)'(NUM_M)) begin
        v_sum = v_sum - (ID_W+1)'(NUM_M);
      end
      v_idx = v_sum[ID_W-1:0];
      if (!w_scan_vld && w_elig[v_idx]) begin
        w_scan_vld = 1'b1;
        w_scan_win = v_idx;
      end
    end
  end

  // Outputs are forced low while reset is asserted.
  assign w_win    = r_lock ? r_lock_id : w_scan_win;
  assign w_vld    = (r_lock | w_scan_vld) & ~rst_i;
  assign w_accept = w_vld & s_ack_i;
  assign w_push   = w_accept & ~m_we_i[w_win];
  assign w_pop    = s_resp_i & ~w_empty & ~rst_i;

  assign s_req_o   = w_vld;
  assign s_we_o    = w_vld & m_we_i[w_win];
  assign s_addr_o  = w_vld ? m_addr_i[w_win*ADDR_W +: ADDR_W]   : '0;
  assign s_be_o    = w_vld ? m_be_i[w_win*BE_W +: BE_W]         : '0;
  assign s_wdata_o = w_vld ? m_wdata_i[w_win*DATA_W +: DATA_W]  : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_M; gi++) begin : g_master
      logic w_is_win;
      logic w_is_head;
      assign w_is_win  = (w_win == ID_W'(gi));
      assign w_is_head = (w_head == ID_W'(gi));
      assign m_ack_o[gi]  = w_accept & w_is_win;
      assign m_resp_o[gi] = w_pop & w_is_head;
      assign m_rdata_o[gi*DATA_W +: DATA_W] = (w_pop & w_is_head) ? s_rdata_i : '0;
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr  <= '0;
      r_lock    <= 1'b0;
      r_lock_id <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_lock   <= 1'b0;
        r_rr_ptr <= f_id_inc(w_win);
      end else if (w_vld) begin
        r_lock    <= 1'b1;
        r_lock_id <= w_win;
      end
      if (w_push) begin
        r_wptr <= f_ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= f_ptr_inc(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (s_resp_i && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  // ID storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo[r_wptr] <= w_win;
    end
  end

  assign outst_cnt_o = r_cnt;
  assign err_o       = r_err;

endmodule

// File: tb/tb_arb_nm1s.sv
// Directed testbench for arb_nm1s: reset, round-robin, lock, in-order reads, full FIFO, spurious response.
module tb_arb_nm1s;

  localparam int NUM_M = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MAX_OUTST = 4;
  localparam int BE_W = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic                    clk_i = 1'b0;
  logic                    rst_i = 1'b0;
  logic [NUM_M-1:0]        m_req_i = '0;
  logic [NUM_M-1:0]        m_we_i = '0;
  logic [NUM_M*ADDR_W-1:0] m_addr_i = '0;
  logic [NUM_M*BE_W-1:0]   m_be_i = '0;
  logic [NUM_M*DATA_W-1:0] m_wdata_i = '0;
  logic [NUM_M-1:0]        m_ack_o;
  logic [NUM_M-1:0]        m_resp_o;
  logic [NUM_M*DATA_W-1:0] m_rdata_o;
  logic                    s_req_o;
  logic                    s_we_o;
  logic [ADDR_W-1:0]       s_addr_o;
  logic [BE_W-1:0]         s_be_o;
  logic [DATA_W-1:0]       s_wdata_o;
  logic                    s_ack_i = 1'b0;
  logic                    s_resp_i = 1'b0;
  logic [DATA_W-1:0]       s_rdata_i = '0;
  logic [CNT_W-1:0]        outst_cnt_o;
  logic                    err_o;

  int checks = 0;
  int errors = 0;

  arb_nm1s #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i), .m_be_i(m_be_i),
    .m_wdata_i(m_wdata_i), .m_ack_o(m_ack_o), .m_resp_o(m_resp_o), .m_rdata_o(m_rdata_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_be_o(s_be_o),
    .s_wdata_o(s_wdata_o), .s_ack_i(s_ack_i), .s_resp_i(s_resp_i), .s_rdata_i(s_rdata_i),
    .outst_cnt_o(outst_cnt_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Each master's address is 0x1000_0000 + i*0x100, so the winner is visible on s_addr_o.
  task automatic set_m(input int i, input logic req, input logic we);
    m_req_i[i] = req;
    m_we_i[i] = we;
    m_addr_i[i*ADDR_W +: ADDR_W] = 32'h1000_0000 + 32'(i * 256);
    m_be_i[i*BE_W +: BE_W] = '1;
    m_wdata_i[i*DATA_W +: DATA_W] = 32'hD000_0000 + 32'(i);
  endtask

  task automatic clear_all();
    m_req_i = '0;
    m_we_i = '0;
    s_ack_i = 1'b0;
    s_resp_i = 1'b0;
    s_rdata_i = '0;
  endtask

  // Inputs change 1 ns after the rising edge; checks run 5 ns after the edge.
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    clear_all();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    next_cycle();
    #4;
    checks++;
    if (s_req_o !== 1'b0) begin errors++; $display("FAIL reset_s_req got=%b exp=0", s_req_o); end
    checks++;
    if (m_ack_o !== 4'b0000) begin errors++; $display("FAIL reset_ack got=%b exp=0000", m_ack_o); end
    checks++;
    if (outst_cnt_o !== 3'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", outst_cnt_o); end
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_o); end
    $display("txn reset: s_req=%b ack=%b cnt=%0d err=%b", s_req_o, m_ack_o, outst_cnt_o, err_o);
  endtask

  task automatic test_round_robin();
    int cnt [NUM_M];
    logic [NUM_M-1:0] exp;
    for (int i = 0; i < NUM_M; i++) cnt[i] = 0;
    next_cycle();
    for (int i = 0; i < NUM_M; i++) set_m(i, 1'b1, 1'b1);
    s_ack_i = 1'b1;
    for (int k = 0; k < 100; k++) begin
      #4;
      exp = 4'b0001 << (k % 4);
      checks++;
      if (m_ack_o !== exp) begin
        errors++;
        $display("FAIL rr_order k=%0d got=%b exp=%b", k, m_ack_o, exp);
      end
      for (int i = 0; i < NUM_M; i++) if (m_ack_o[i] === 1'b1) cnt[i]++;
      next_cycle();
    end
    clear_all();
    for (int i = 0; i < NUM_M; i++) begin
      checks++;
      if (cnt[i] !== 25) begin errors++; $display("FAIL rr_count m%0d got=%0d exp=25", i, cnt[i]); end
      $display("txn rr: master %0d got %0d acks", i, cnt[i]);
    end
    #4;
    checks++;
    if (outst_cnt_o !== 3'd0) begin errors++; $display("FAIL rr_cnt got=%0d exp=0", outst_cnt_o); end
  endtask

  task automatic test_lock();
    // rr_ptr is 0 here; m1 is the only requester at first, so it wins and locks.
    next_cycle();
    set_m(1, 1'b1, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) set_m(0, 1'b1, 1'b1);
      if (c == 4) s_ack_i = 1'b1;
      #4;
      checks++;
      if (s_addr_o !== 32'h1000_0100) begin
        errors++;
        $display("FAIL lock_addr c=%0d got=%h exp=10000100", c, s_addr_o);
      end
      checks++;
      if (m_ack_o !== ((c == 4) ? 4'b0010 : 4'b0000)) begin
        errors++;
        $display("FAIL lock_ack c=%0d got=%b exp=%b", c, m_ack_o, (c == 4) ? 4'b0010 : 4'b0000);
      end
      $display("txn lock c=%0d: addr=%h ack=%b", c, s_addr_o, m_ack_o);
      next_cycle();
    end
    set_m(1, 1'b0, 1'b1);
    set_m(2, 1'b1, 1'b1);
    set_m(3, 1'b1, 1'b1);
    #4;
    checks++;
    if (m_ack_o !== 4'b0100) begin errors++; $display("FAIL lock_next got=%b exp=0100", m_ack_o); end
    $display("txn lock next: ack=%b", m_ack_o);
    next_cycle();
    clear_all();
  endtask

  task automatic test_reads();
    logic [NUM_M*DATA_W-1:0] exp_rd;
    int order [3] = '{2, 0, 3};
    logic [NUM_M-1:0] exp_resp [3] = '{4'b0100, 4'b0001, 4'b1000};
    logic [DATA_W-1:0] rd [3] = '{32'hA, 32'hB, 32'hC};
    for (int k = 0; k < 3; k++) begin
      clear_all();
      set_m(order[k], 1'b1, 1'b0);
      s_ack_i = 1'b1;
      #4;
      checks++;
      if (m_ack_o !== exp_resp[k]) begin errors++; $display("FAIL rd_ack k=%0d got=%b exp=%b", k, m_ack_o, exp_resp[k]); end
      checks++;
      if (outst_cnt_o !== 3'(k)) begin errors++; $display("FAIL rd_cnt_up k=%0d got=%0d exp=%0d", k, outst_cnt_o, k); end
      $display("txn read issue m%0d: ack=%b cnt=%0d", order[k], m_ack_o, outst_cnt_o);
      next_cycle();
    end
    for (int k = 0; k < 3; k++) begin
      clear_all();
      s_resp_i = 1'b1;
      s_rdata_i = rd[k];
      #4;
      exp_rd = '0;
      exp_rd[order[k]*DATA_W +: DATA_W] = rd[k];
      checks++;
      if (outst_cnt_o !== 3'(3 - k)) begin errors++; $display("FAIL rd_cnt_dn k=%0d got=%0d exp=%0d", k, outst_cnt_o, 3 - k); end
      checks++;
      if (m_resp_o !== exp_resp[k]) begin errors++; $display("FAIL rd_resp k=%0d got=%b exp=%b", k, m_resp_o, exp_resp[k]); end
      checks++;
      if (m_rdata_o !== exp_rd) begin errors++; $display("FAIL rd_data k=%0d got=%h exp=%h", k, m_rdata_o, exp_rd); end
      $display("txn read resp: resp=%b data=%h", m_resp_o, s_rdata_i);
      next_cycle();
    end
    clear_all();
    #4;
    checks++;
    if (outst_cnt_o !== 3'd0) begin errors++; $display("FAIL rd_cnt_end got=%0d exp=0", outst_cnt_o); end
  endtask

  task automatic test_fifo_full();
    next_cycle();
    set_m(0, 1'b1, 1'b0);
    s_ack_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #4;
      checks++;
      if (m_ack_o !== 4'b0001) begin errors++; $display("FAIL full_fill k=%0d got=%b exp=0001", k, m_ack_o); end
      next_cycle();
    end
    set_m(1, 1'b1, 1'b1);
    #4;
    checks++;
    if (outst_cnt_o !== 3'd4) begin errors++; $display("FAIL full_cnt got=%0d exp=4", outst_cnt_o); end
    checks++;
    if (m_ack_o !== 4'b0010) begin errors++; $display("FAIL full_mask got=%b exp=0010", m_ack_o); end
    $display("txn full: read masked, write ack=%b", m_ack_o);
    next_cycle();
    set_m(1, 1'b0, 1'b1);
    s_resp_i = 1'b1;
    s_rdata_i = 32'h55;
    #4;
    checks++;
    if (m_ack_o !== 4'b0000) begin errors++; $display("FAIL full_pop_ack got=%b exp=0000", m_ack_o); end
    checks++;
    if (m_resp_o !== 4'b0001) begin errors++; $display("FAIL full_pop_resp got=%b exp=0001", m_resp_o); end
    next_cycle();
    s_resp_i = 1'b0;
    #4;
    checks++;
    if (outst_cnt_o !== 3'd3) begin errors++; $display("FAIL full_cnt3 got=%0d exp=3", outst_cnt_o); end
    checks++;
    if (m_ack_o !== 4'b0001) begin errors++; $display("FAIL full_reack got=%b exp=0001", m_ack_o); end
    $display("txn full: m0 read re-acked ack=%b", m_ack_o);
    next_cycle();
    clear_all();
    #4;
    checks++;
    if (outst_cnt_o !== 3'd4) begin errors++; $display("FAIL full_cnt4 got=%0d exp=4", outst_cnt_o); end
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      s_resp_i = 1'b1;
      s_rdata_i = 32'(k);
      #4;
      checks++;
      if (m_resp_o !== 4'b0001) begin errors++; $display("FAIL full_drain k=%0d got=%b exp=0001", k, m_resp_o); end
      next_cycle();
    end
    clear_all();
    #4;
    checks++;
    if (outst_cnt_o !== 3'd0) begin errors++; $display("FAIL full_drained got=%0d exp=0", outst_cnt_o); end
  endtask

  task automatic test_spurious_reset();
    next_cycle();
    set_m(1, 1'b1, 1'b0);
    s_ack_i = 1'b1;
    #4;
    checks++;
    if (m_ack_o !== 4'b0010) begin errors++; $display("FAIL sp_issue got=%b exp=0010", m_ack_o); end
    next_cycle();
    clear_all();
    #4;
    checks++;
    if (outst_cnt_o !== 3'd1) begin errors++; $display("FAIL sp_cnt1 got=%0d exp=1", outst_cnt_o); end
    // Asynchronous reset between edges discards the in-flight read.
    #1 rst_i = 1'b1;
    set_m(0, 1'b1, 1'b1);
    s_ack_i = 1'b1;
    #1;
    checks++;
    if (outst_cnt_o !== 3'd0) begin errors++; $display("FAIL sp_rst_cnt got=%0d exp=0", outst_cnt_o); end
    checks++;
    if (s_req_o !== 1'b0 || m_ack_o !== 4'b0000) begin
      errors++;
      $display("FAIL sp_rst_out s_req=%b ack=%b exp 0/0000", s_req_o, m_ack_o);
    end
    clear_all();
    #1 rst_i = 1'b0;
    next_cycle();
    s_resp_i = 1'b1;
    s_rdata_i = 32'hBAD;
    #4;
    checks++;
    if (m_resp_o !== 4'b0000) begin errors++; $display("FAIL sp_resp got=%b exp=0000", m_resp_o); end
    next_cycle();
    s_resp_i = 1'b0;
    #4;
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL sp_err got=%b exp=1", err_o); end
    $display("txn spurious: resp=%b err=%b", m_resp_o, err_o);
    #1 rst_i = 1'b1;
    #1;
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL sp_err_clr got=%b exp=0", err_o); end
    $display("txn async reset: err=%b", err_o);
    #1 rst_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_reads();
    test_fifo_full();
    test_spurious_reset();
    repeat (2) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout after 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
